word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 98 +++++++++
 tb/tb_word_serializer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//
// Purpose:
//   Captures an N-word parallel frame and presents it one NB-bit word per
//   enabled clock cycle, word 0 (least significant word) first. A new frame
//   can be accepted while the last word of the current frame is presented,
//   which gives gap-free back-to-back streaming.
//
// Ports:
//   i_clock     in   1     rising-edge clock
//   i_reset     in   1     asynchronous active-low reset
//   i_enable    in   1     clock enable; all state holds while low
//   i_load      in   1     request to capture i_data as a new frame
//   i_data      in   N*NB  parallel frame, word k at [(k+1)*NB-1 : k*NB]
//   o_data      out  NB    current serial word (0 while idle)
//   o_valid     out  1     o_data carries a frame word
//   o_last      out  1     word N-1 is being presented
//   o_ready     out  1     combinational: a load would be accepted this edge
//   o_load_err  out  1     one-cycle pulse after a rejected load request
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int N  = 21,
  parameter int NB = 18
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic            i_load,
  input  logic [N*NB-1:0] i_data,
  output logic [NB-1:0]   o_data,
  output logic            o_valid,
  output logic            o_last,
  output logic            o_ready,
  output logic            o_load_err
);

  // N=1 still needs a one-bit index so the counter has a legal width.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [N*NB-1:0] frame_q;
  logic            at_last;
  logic            accept;

  assign at_last = (state == SEND) && (idx == LAST_IDX);
  assign o_ready = (state == IDLE) || at_last;
  assign accept  = i_enable && i_load && o_ready;

  // frame_q holds only the words not yet moved into o_data; it shifts right
  // one word per advance so the next word is always in its low NB bits.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      idx        <= '0;
      frame_q    <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      // A rejected request is reported for exactly one cycle.
      o_load_err <= i_enable && i_load && !o_ready;

      if (i_enable) begin
        if (accept) begin
          state   <= SEND;
          idx     <= '0;
          frame_q <= i_data >> NB;
          o_data  <= i_data[NB-1:0];
          o_valid <= 1'b1;
          o_last  <= (N == 1);
        end else if (state == SEND) begin
          if (idx == LAST_IDX) begin
            state   <= IDLE;
            idx     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end else begin
            idx     <= idx + 1'b1;
            frame_q <= frame_q >> NB;
            o_data  <= frame_q[NB-1:0];
            o_last  <= ((idx + 1'b1) == LAST_IDX);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//
// Bench for word_serializer. A small instance (N=4, NB=8) runs the directed
// frames; a scoreboard queue holds the words each accepted frame must produce
// and a monitor compares whatever the DUT presents against the queue head.
// A default-size instance (N=21, NB=18) drives a deserializer model and each
// rebuilt frame is compared with the frame that was loaded.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int N4  = 4;
  localparam int NB4 = 8;
  localparam int N21  = 21;
  localparam int NB21 = 18;
  localparam int W21  = N21 * NB21;

  typedef struct {
    logic [NB4-1:0] data;
    logic           last;
  } exp_word_t;

  logic i_clock;
  logic i_reset;

  // small instance
  logic               i_enable;
  logic               i_load;
  logic [N4*NB4-1:0]  i_data;
  logic [NB4-1:0]     o_data;
  logic               o_valid;
  logic               o_last;
  logic               o_ready;
  logic               o_load_err;

  // loopback instance
  logic               en21;
  logic               ld21;
  logic [W21-1:0]     d21;
  logic [NB21-1:0]    data21;
  logic               valid21;
  logic               last21;
  logic               ready21;
  logic               err21;

  exp_word_t      exp_q[$];
  logic [W21-1:0] frame_q[$];
  logic [W21-1:0] deser;

  int vectors = 0;
  int errs    = 0;

  word_serializer #(.N(N4), .NB(NB4)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_load     (i_load),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_ready    (o_ready),
    .o_load_err (o_load_err)
  );

  word_serializer #(.N(N21), .NB(NB21)) dut21 (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_enable   (en21),
    .i_load     (ld21),
    .i_data     (d21),
    .o_data     (data21),
    .o_valid    (valid21),
    .o_last     (last21),
    .o_ready    (ready21),
    .o_load_err (err21)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the next rising edge.
  task automatic applyStimulus(input logic ld, input logic [N4*NB4-1:0] d, input logic en);
    i_load   = ld;
    i_data   = d;
    i_enable = en;
    @(posedge i_clock);
    #1;
  endtask

  task automatic pushFrame(input logic [N4*NB4-1:0] f);
    exp_word_t w;
    for (int k = 0; k < N4; k++) begin
      w.data = f[k*NB4 +: NB4];
      w.last = (k == N4 - 1);
      exp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor for the small instance: a presented word must match
  // the queue head; it is consumed only when the enable is high at the edge.
  always @(negedge i_clock) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errs++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", o_data);
      end else begin
        checkOutput("word_data", 64'(o_data), 64'(exp_q[0].data));
        checkOutput("word_last", 64'(o_last), 64'(exp_q[0].last));
        if (i_enable)
          exp_q.delete(0);
      end
    end else begin
      checkOutput("idle_data", 64'(o_data), 64'd0);
      checkOutput("idle_last", 64'(o_last), 64'd0);
    end
  end

  // Deserializer model: right shift, new word inserted at the top.
  always @(negedge i_clock) begin : deser_mon
    logic [W21-1:0] nxt;
    if (en21 && valid21) begin
      nxt = {data21, deser[W21-1:NB21]};
      deser <= nxt;
      if (last21) begin
        vectors++;
        if (frame_q.size() == 0) begin
          errs++;
          $display("[TB] FAIL loopback_extra: got %0h expected none", nxt);
        end else begin
          if (nxt !== frame_q[0]) begin
            errs++;
            $display("[TB] FAIL loopback_frame: got %0h expected %0h", nxt, frame_q[0]);
          end
          frame_q.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [383:0] rnd;
    logic [W21-1:0] fr;
    int cnt;
    logic ok;

    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_load   = 1'b0;
    i_data   = '0;
    en21     = 1'b0;
    ld21     = 1'b0;
    d21      = '0;
    deser    = '0;

    // Reset state
    #3;
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_data", 64'(o_data), 64'd0);
    checkOutput("rst_last", 64'(o_last), 64'd0);
    checkOutput("rst_ready", 64'(o_ready), 64'd1);
    checkOutput("rst_err", 64'(o_load_err), 64'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);

    // Basic frame, i_data scrambled after acceptance
    $display("[TB] basic frame");
    pushFrame(32'h44332211);
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    checkOutput("lat_valid", 64'(o_valid), 64'd1);
    checkOutput("lat_data", 64'(o_data), 64'h11);
    checkOutput("ready_mid", 64'(o_ready), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'hA5A5A5A5, 1'b1);
    checkOutput("end_valid", 64'(o_valid), 64'd0);
    checkOutput("end_ready", 64'(o_ready), 64'd1);
    checkOutput("end_q_empty", 64'(exp_q.size()), 64'd0);

    // Enable toggling; a load while disabled is ignored silently
    $display("[TB] enable toggling");
    pushFrame(32'h44332211);
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i == 2, 32'hDEADBEEF, 1'(i % 2));
      checkOutput("tog_valid", 64'(o_valid), (i < 7) ? 64'd1 : 64'd0);
      if (i == 2) checkOutput("dis_load_err", 64'(o_load_err), 64'd0);
    end

    // Back-to-back frames with no gap
    $display("[TB] back-to-back");
    pushFrame(32'h44332211);
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("b2b_valid_a", 64'(o_valid), 64'd1);
    end
    checkOutput("b2b_ready_last", 64'(o_ready), 64'd1);
    pushFrame(32'h88776655);
    applyStimulus(1'b1, 32'h88776655, 1'b1);
    checkOutput("b2b_first_b", 64'(o_data), 64'h55);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("b2b_valid_b", 64'(o_valid), 64'd1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_end_valid", 64'(o_valid), 64'd0);

    // Rejected load
    $display("[TB] rejected load");
    pushFrame(32'h44332211);
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
    checkOutput("rej_err_pulse", 64'(o_load_err), 64'd1);
    checkOutput("rej_data", 64'(o_data), 64'h33);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rej_err_clear", 64'(o_load_err), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rej_end_valid", 64'(o_valid), 64'd0);

    // Reset mid-frame
    $display("[TB] reset mid-frame");
    pushFrame(32'h44332211);
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pre_rst_data", 64'(o_data), 64'h33);
    i_reset = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("mid_rst_valid", 64'(o_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(o_data), 64'd0);
    checkOutput("mid_rst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_valid", 64'(o_valid), 64'd0);
    checkOutput("post_rst_ready", 64'(o_ready), 64'd1);
    pushFrame(32'h88776655);
    applyStimulus(1'b1, 32'h88776655, 1'b1);
    checkOutput("post_rst_first", 64'(o_data), 64'h55);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_end", 64'(o_valid), 64'd0);
    i_enable = 1'b0;

    // Loopback with the default-size instance, random enable gaps
    $display("[TB] loopback");
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 12; k++) rnd[k*32 +: 32] = $urandom;
      fr = rnd[W21-1:0];
      cnt = 0;
      while (!ready21 && cnt < 200) begin
        en21 = ($urandom_range(0, 3) != 0);
        @(posedge i_clock);
        #1;
        cnt++;
      end
      ok = ready21;
      if (!ok) begin
        vectors++;
        errs++;
        $display("[TB] FAIL loopback_ready_timeout: got 0 expected 1");
      end
      ld21 = 1'b1;
      en21 = 1'b1;
      d21  = fr;
      frame_q.push_back(fr);
      @(posedge i_clock);
      #1;
      ld21 = 1'b0;
      d21  = ~fr;
    end
    cnt = 0;
    while (valid21 && cnt < 200) begin
      en21 = ($urandom_range(0, 3) != 0);
      @(posedge i_clock);
      #1;
      cnt++;
    end
    en21 = 1'b0;
    @(posedge i_clock);
    #1;
    checkOutput("loopback_drained", 64'(frame_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
